timer_sequencer: RTL and testbench
==================================

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clock cycles per second; SHALL be even and >= 2.
REQ-002 Port clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port start_timer  input  1  request from the anti-theft FSM to begin a countdown, sampled each cycle.
REQ-005 Port abort  input  1  cancels any countdown without an expiry.
REQ-006 Port interval  input  2  selects the countdown parameter: 00 arm delay, 01 driver delay, 10 passenger delay, 11 alarm-on time.
REQ-007 Port reprogram  input  1  write strobe for the parameter bank.
REQ-008 Port time_param_sel  input  2  parameter index written on reprogram.
REQ-009 Port time_value  input  4  seconds value written on reprogram.
REQ-010 Port value  output  4  current bank content at index time_param_sel, combinational.
REQ-011 Port remaining  output  4  seconds left in the active countdown.
REQ-012 Port busy  output  1  high in LOAD and COUNT.
REQ-013 Port expired  output  1  single-cycle pulse when a countdown completes.
REQ-014 Port one_hz_enable  output  1  single-cycle tick once per CLK_HZ cycles.
REQ-015 Port two_hz_enable  output  1  single-cycle tick twice per CLK_HZ cycles, for the siren generator.

Function
REQ-016 The parameter bank SHALL be 4 x 4-bit registers; reprogram writes time_value to entry time_param_sel on the next edge.
REQ-017 A reprogram during a countdown SHALL NOT alter the loaded count.
REQ-018 The prescaler SHALL count 0..CLK_HZ-1 and wrap.
  - one_hz_enable is high at count CLK_HZ-1.
  - two_hz_enable is high at counts CLK_HZ/2-1 and CLK_HZ-1.
REQ-019 The prescaler SHALL be cleared to 0 in LOAD; otherwise it runs freely.
REQ-020 The FSM SHALL have four states, IDLE, LOAD, COUNT and DONE, with these transitions:
  - IDLE: to LOAD on start_timer.
  - LOAD: latch bank[interval] into remaining; to DONE if the latched value is 0, else to COUNT.
  - COUNT: decrement remaining on one_hz_enable; to DONE on the tick that takes remaining from 1 to 0.
  - DONE: expired=1 for exactly one cycle; then to IDLE, or to LOAD if start_timer is high.
REQ-021 Latency: with start_timer sampled in cycle n and value V>0, expired SHALL be high in cycle n+2+V*CLK_HZ; with V=0, in cycle n+2.
REQ-022 start_timer in LOAD or COUNT SHALL restart the countdown: go to LOAD, re-latch using the current interval, no expired pulse.
REQ-023 abort in LOAD or COUNT SHALL go to IDLE, clear remaining to 0 and produce no expired pulse.
REQ-024 abort SHALL win over a simultaneous start_timer.
REQ-025 abort in DONE SHALL NOT suppress that cycle's expired pulse.
REQ-026 remaining SHALL hold 0 in IDLE and after DONE.

Reset
REQ-027 When reset is low, the block SHALL immediately enter IDLE with:
  - remaining=0, prescaler=0, expired=0, busy=0, one_hz_enable=0, two_hz_enable=0;
  - bank = {6, 8, 15, 10} for indices 00..11.
REQ-028 Reset asserted mid-countdown SHALL discard the countdown and reprogrammed values, with no expired pulse.
REQ-029 Deassertion of reset SHALL take effect on the next rising clock edge.

Structure
REQ-030 A shared package timer_pkg SHALL hold:
  - the state encoding;
  - the interval codes (ARM, DRIVER, PASSENGER, ALARM_ON);
  - the default parameter constants.
REQ-031 The prescaler SHALL be a sub-module, one_hz_prescaler, with a clear input and CLK_HZ parameter; FSM, bank and countdown reside in timer_sequencer.

Verification (bench uses CLK_HZ=4)
REQ-032 Reset, then start_timer with interval=00 in cycle 10 -> busy from cycle 11, expired high only in cycle 36, remaining 6->0.
REQ-033 Reprogram index 01 to 0, then start with interval=01 -> expired exactly 2 cycles after start, no one_hz-based decrement.
REQ-034 Start interval=10 (15), abort after 3 ticks -> remaining=0, busy=0, no expired pulse for 80 cycles.
REQ-035 Start interval=11, re-start with interval=00 after 2 ticks -> reloads 6, single expired 2+24 cycles after the second start.
REQ-036 Reprogram index 00 to 3 during an active interval=00 countdown -> current countdown still expires after 6 s; next start uses 3.
REQ-037 Assert reset mid-COUNT -> all outputs 0 immediately, value reads defaults 6/8/15/10, no expired pulse afterwards.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the anti-theft timer sequencer: FSM state encoding,
// interval codes and the power-on contents of the parameter bank.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_e;

  typedef enum logic [1:0] {
    ARM       = 2'b00,
    DRIVER    = 2'b01,
    PASSENGER = 2'b10,
    ALARM_ON  = 2'b11
  } interval_e;

  localparam logic [3:0] DEFAULT_ARM       = 4'd6;
  localparam logic [3:0] DEFAULT_DRIVER    = 4'd8;
  localparam logic [3:0] DEFAULT_PASSENGER = 4'd15;
  localparam logic [3:0] DEFAULT_ALARM_ON  = 4'd10;

  function automatic logic [3:0] default_param(input logic [1:0] idx);
    logic [3:0] v;
    case (interval_e'(idx))
      ARM:       v = DEFAULT_ARM;
      DRIVER:    v = DEFAULT_DRIVER;
      PASSENGER: v = DEFAULT_PASSENGER;
      default:   v = DEFAULT_ALARM_ON;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/one_hz_prescaler.sv
// Free-running 0..CLK_HZ-1 counter producing 1 Hz and 2 Hz single-cycle ticks;
// clear restarts the second so a fresh countdown gets whole seconds.
module one_hz_prescaler #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic one_hz_enable,
  output logic two_hz_enable
);

  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2 - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear || count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign one_hz_enable = (count_q == LAST);
  assign two_hz_enable = (count_q == LAST) || (count_q == HALF);

endmodule

// File: rtl/timer_sequencer.sv
// Countdown sequencer for the anti-theft FSM: a reprogrammable 4-entry bank of
// second counts, an IDLE/LOAD/COUNT/DONE FSM and a shared 1 Hz / 2 Hz prescaler.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start_timer,
  input  logic         abort,
  input  logic [1:0]   interval,
  input  logic         reprogram,
  input  logic [1:0]   time_param_sel,
  input  logic [3:0]   time_value,
  output logic [3:0]   value,
  output logic [3:0]   remaining,
  output logic         busy,
  output logic         expired,
  output logic         one_hz_enable,
  output logic         two_hz_enable,
  output timer_state_e state_dbg
);

  timer_state_e state_q, state_d;
  logic [3:0]   rem_q, rem_d;
  logic [3:0]   bank_q [4];
  logic         presc_clear;

  // The bank is independent of the countdown, so a write never disturbs rem_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) bank_q[i] <= default_param(2'(i));
    end else if (reprogram) begin
      bank_q[time_param_sel] <= time_value;
    end
  end

  assign value = bank_q[time_param_sel];

  assign presc_clear = (state_q == ST_LOAD);

  one_hz_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clock         (clock),
    .reset         (reset),
    .clear         (presc_clear),
    .one_hz_enable (one_hz_enable),
    .two_hz_enable (two_hz_enable)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // abort beats start_timer everywhere; in DONE the expiry pulse is already out.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        rem_d = '0;
        if (start_timer && !abort) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else begin
          rem_d = bank_q[interval];
          if (start_timer)                state_d = ST_LOAD;
          else if (bank_q[interval] == 0) state_d = ST_DONE;
          else                            state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (abort) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else if (start_timer) begin
          state_d = ST_LOAD;
        end else if (one_hz_enable) begin
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = ST_DONE;
        end
      end
      default: begin
        rem_d   = '0;
        state_d = (start_timer && !abort) ? ST_LOAD : ST_IDLE;
      end
    endcase
  end

  assign remaining = rem_q;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_COUNT);
  assign expired   = (state_q == ST_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer at CLK_HZ=4: directed corner sequences, table-driven
// bank/latency vectors and random traffic against a cycle-arithmetic model.
module tb_timer_sequencer;
  import timer_pkg::*;

  localparam int CLK_HZ = 4;

  logic         clock;
  logic         reset;
  logic         start_timer;
  logic         abort;
  logic [1:0]   interval;
  logic         reprogram;
  logic [1:0]   time_param_sel;
  logic [3:0]   time_value;
  logic [3:0]   value;
  logic [3:0]   remaining;
  logic         busy;
  logic         expired;
  logic         one_hz_enable;
  logic         two_hz_enable;
  timer_state_e state_dbg;

  timer_sequencer #(.CLK_HZ(CLK_HZ)) dut (
    .clock          (clock),
    .reset          (reset),
    .start_timer    (start_timer),
    .abort          (abort),
    .interval       (interval),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .value          (value),
    .remaining      (remaining),
    .busy           (busy),
    .expired        (expired),
    .one_hz_enable  (one_hz_enable),
    .two_hz_enable  (two_hz_enable),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] val;
  } dflt_t;

  typedef struct {
    logic [1:0] iv;
    logic [3:0] wv;
    int         lat;
  } lat_t;

  dflt_t dflt_tab [4];
  lat_t  lat_tab  [4];

  int n_vec;
  int n_miss;
  int cyc;
  int exp_count;
  int exp_last;
  int first_busy;

  // reference model: countdown described by its load cycle and expiry cycle
  logic [3:0] m_bank [4];
  bit         m_active;
  int         m_load_cyc;
  int         m_expire;
  int         m_v;
  bit         m_prev_load;
  int         m_rem_prev;
  int         m_base;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_bank[i] = dflt_tab[i].val;
    m_active    = 1'b0;
    m_load_cyc  = -1;
    m_expire    = -1;
    m_v         = 0;
    m_prev_load = 1'b0;
    m_rem_prev  = 0;
  endtask

  task automatic clear_counts();
    exp_count  = 0;
    exp_last   = -1;
    first_busy = -1;
  endtask

  // One clock cycle: compare outputs mid-cycle, advance the model, cross the edge.
  task automatic step();
    bit is_done, is_load, e_busy;
    int e_rem, ph;
    #2;
    is_done = m_active && (m_expire >= 0) && (cyc == m_expire);
    is_load = m_active && (cyc == m_load_cyc);
    e_busy  = m_active && !is_done;
    if (!e_busy)      e_rem = 0;
    else if (is_load) e_rem = m_prev_load ? m_v : m_rem_prev;
    else              e_rem = m_v - (cyc - (m_load_cyc + 1)) / CLK_HZ;
    ph = (cyc - m_base) % CLK_HZ;

    check("busy", int'(busy), int'(e_busy));
    check("expired", int'(expired), int'(is_done));
    check("remaining", int'(remaining), e_rem);
    check("one_hz", int'(one_hz_enable), int'(ph == CLK_HZ - 1));
    check("two_hz", int'(two_hz_enable), int'(ph == CLK_HZ - 1 || ph == CLK_HZ / 2 - 1));
    check("value", int'(value), int'(m_bank[time_param_sel]));

    if (expired) begin
      exp_count++;
      exp_last = cyc;
    end
    if (busy && first_busy < 0) first_busy = cyc;

    m_rem_prev  = e_rem;
    m_prev_load = is_load;
    if (is_done) m_active = 1'b0;
    if (is_load) begin
      m_v      = m_bank[interval];
      m_expire = cyc + 1 + m_v * CLK_HZ;
      m_base   = cyc + 1;
    end
    if (e_busy && abort) begin
      m_active = 1'b0;
      m_expire = -1;
    end else if (start_timer && !abort) begin
      m_active   = 1'b1;
      m_load_cyc = cyc + 1;
      m_expire   = -1;
    end
    if (reprogram) m_bank[time_param_sel] = time_value;

    @(posedge clock);
    #1;
    cyc++;
  endtask

  // driver tasks
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start(input logic [1:0] iv);
    interval    = iv;
    start_timer = 1'b1;
    step();
    start_timer = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic do_prog(input logic [1:0] sel, input logic [3:0] v);
    reprogram      = 1'b1;
    time_param_sel = sel;
    time_value     = v;
    step();
    reprogram      = 1'b0;
  endtask

  task automatic apply_reset(input int hold);
    start_timer = 1'b0;
    abort       = 1'b0;
    reprogram   = 1'b0;
    reset       = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_expired", int'(expired), 0);
    check("rst_remaining", int'(remaining), 0);
    check("rst_one_hz", int'(one_hz_enable), 0);
    check("rst_two_hz", int'(two_hz_enable), 0);
    check("rst_state", int'(state_dbg), int'(ST_IDLE));
    for (int i = 0; i < 4; i++) begin
      time_param_sel = dflt_tab[i].sel;
      #1;
      check("rst_value", int'(value), int'(dflt_tab[i].val));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check("rst_hold_expired", int'(expired), 0);
    end
    model_reset();
    clear_counts();
    reset  = 1'b1;
    m_base = cyc;
  endtask

  int s;

  initial begin
    dflt_tab[0] = '{2'd0, 4'd6};
    dflt_tab[1] = '{2'd1, 4'd8};
    dflt_tab[2] = '{2'd2, 4'd15};
    dflt_tab[3] = '{2'd3, 4'd10};
    lat_tab[0]  = '{2'd1, 4'd0, 2};
    lat_tab[1]  = '{2'd2, 4'd1, 6};
    lat_tab[2]  = '{2'd3, 4'd2, 10};
    lat_tab[3]  = '{2'd0, 4'd3, 14};

    n_vec = 0;
    n_miss = 0;
    cyc = 0;
    m_base = 0;
    reset = 1'b1;
    start_timer = 1'b0;
    abort = 1'b0;
    interval = 2'd0;
    reprogram = 1'b0;
    time_param_sel = 2'd0;
    time_value = 4'd0;
    #2;
    apply_reset(3);

    // arm delay from cycle 10: busy from 11, single expiry at 36
    run(10);
    clear_counts();
    do_start(2'd0);
    run(29);
    check("arm_first_busy", first_busy, 11);
    check("arm_expire_cnt", exp_count, 1);
    check("arm_expire_cyc", exp_last, 36);

    // zero-second driver delay expires two cycles after start
    do_prog(2'd1, 4'd0);
    clear_counts();
    s = cyc;
    do_start(2'd1);
    run(6);
    check("zero_expire_cnt", exp_count, 1);
    check("zero_expire_cyc", exp_last, s + 2);

    // passenger delay aborted after three ticks
    clear_counts();
    s = cyc;
    do_start(2'd2);
    run(13);
    check("abort_rem_before", int'(remaining), 12);
    do_abort();
    check("abort_busy", int'(busy), 0);
    check("abort_remaining", int'(remaining), 0);
    run(80);
    check("abort_expire_cnt", exp_count, 0);

    // alarm-on restarted as arm delay after two ticks
    clear_counts();
    s = cyc;
    do_start(2'd3);
    run(9);
    check("restart_rem_before", int'(remaining), 8);
    s = cyc;
    do_start(2'd0);
    run(30);
    check("restart_expire_cnt", exp_count, 1);
    check("restart_expire_cyc", exp_last, s + 26);

    // reprogram during an arm countdown affects only the next start
    clear_counts();
    s = cyc;
    do_start(2'd0);
    run(5);
    do_prog(2'd0, 4'd3);
    run(30);
    check("reprog_expire_cnt", exp_count, 1);
    check("reprog_expire_cyc", exp_last, s + 26);
    clear_counts();
    s = cyc;
    do_start(2'd0);
    run(18);
    check("reprog_next_cnt", exp_count, 1);
    check("reprog_next_cyc", exp_last, s + 14);

    // reset in the middle of a countdown discards it and the bank writes
    do_prog(2'd3, 4'd5);
    do_start(2'd2);
    run(10);
    apply_reset(3);
    run(80);
    check("rst_mid_expire_cnt", exp_count, 0);

    // table: program an entry, start it, measure start-to-expiry latency
    for (int i = 0; i < 4; i++) begin
      do_prog(lat_tab[i].iv, lat_tab[i].wv);
      run(1);
      clear_counts();
      s = cyc;
      do_start(lat_tab[i].iv);
      run(lat_tab[i].lat + 3);
      check("tab_expire_cnt", exp_count, 1);
      check("tab_latency", exp_last - s, lat_tab[i].lat);
    end

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start_timer    = ($urandom_range(0, 39) == 0);
      abort          = ($urandom_range(0, 79) == 0);
      reprogram      = ($urandom_range(0, 29) == 0);
      interval       = 2'($urandom_range(0, 3));
      time_param_sel = 2'($urandom_range(0, 3));
      time_value     = 4'($urandom_range(0, 15));
      step();
    end
    start_timer = 1'b0;
    abort       = 1'b0;
    reprogram   = 1'b0;
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
